// File: rtl/tdm_demux4x1_pkg.sv
// Shared types and constants for the 4-channel TDM receive demultiplexer.
package tdm_demux4x1_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int SLOT_W = 2;
    localparam int N_CH   = 4;
    localparam int MISS_W = 3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index tracker: wraps 3->0, reloads to 1 on a slot-0 sample, clears on loss of lock.
module tdm_slot_counter
    import tdm_demux4x1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load,
    input  logic              clr,
    output logic [SLOT_W-1:0] slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load) begin
            slot <= SLOT_W'(1);
        end else if (inc) begin
            slot <= slot + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux4x1.sv
// Receive end of a 4-slot TDM link: rebuilds each frame, tracks lock and flags framing errors.
module tdm_demux4x1
    import tdm_demux4x1_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int MISS_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              in_valid,
    input  logic              frame_sync,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);

    state_e              state, state_nx;
    logic [MISS_W-1:0]   miss_q, miss_nx;
    logic [SLOT_W-1:0]   slot_q;
    logic [WIDTH-1:0]    shadow [N_CH-1];

    logic at_slot0, at_last, miss_hit, lk_vld;
    logic ev_acq, ev_early, ev_sync0, ev_miss, ev_lost, ev_mid, ev_last;
    logic cnt_inc, cnt_load, cnt_clr, cap_en, frame_done, err_nx;
    logic [SLOT_W-1:0] cap_idx;

    // One event per accepted sample; at most one of these is high in any cycle.
    assign at_slot0 = (slot_q == '0);
    assign at_last  = (slot_q == SLOT_W'(N_CH - 1));
    assign miss_hit = (miss_q == MISS_W'(MISS_LIMIT - 1));
    assign lk_vld   = in_valid && (state == ST_LOCKED);

    assign ev_acq   = in_valid && (state == ST_HUNT) && frame_sync;
    assign ev_early = lk_vld && frame_sync && !at_slot0;
    assign ev_sync0 = lk_vld && frame_sync && at_slot0;
    assign ev_miss  = lk_vld && !frame_sync && at_slot0 && !miss_hit;
    assign ev_lost  = lk_vld && !frame_sync && at_slot0 && miss_hit;
    assign ev_mid   = lk_vld && !frame_sync && !at_slot0 && !at_last;
    assign ev_last  = lk_vld && !frame_sync && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_HUNT;
            miss_q <= '0;
        end else begin
            state  <= state_nx;
            miss_q <= miss_nx;
        end
    end

    always_comb begin
        state_nx = state;
        miss_nx  = miss_q;
        if (ev_acq) begin
            state_nx = ST_LOCKED;
            miss_nx  = '0;
        end
        if (ev_early || ev_sync0) miss_nx = '0;
        if (ev_miss)              miss_nx = miss_q + MISS_W'(1);
        if (ev_lost) begin
            state_nx = ST_HUNT;
            miss_nx  = '0;
        end
    end

    // Every sample treated as slot 0 reloads the counter to 1 and writes shadow[0].
    always_comb begin
        cnt_load   = ev_acq || ev_early || ev_sync0 || ev_miss;
        cnt_inc    = ev_mid || ev_last;
        cnt_clr    = ev_lost;
        cap_en     = cnt_load || ev_mid;
        cap_idx    = cnt_load ? '0 : slot_q;
        frame_done = ev_last;
        err_nx     = ev_early || ev_lost;
    end

    tdm_slot_counter u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .load  (cnt_load),
        .clr   (cnt_clr),
        .slot  (slot_q)
    );

    // Output stage: all four channels update together on the slot-3 sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH - 1; i++) shadow[i] <= '0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            sync_err    <= err_nx;
            for (int i = 0; i < N_CH - 1; i++) begin
                if (cap_en && (cap_idx == SLOT_W'(i))) shadow[i] <= in;
            end
            if (frame_done) begin
                out0 <= shadow[0];
                out1 <= shadow[1];
                out2 <= shadow[2];
                out3 <= in;
            end
        end
    end

    assign slot   = slot_q;
    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4x1.sv
// Bench for tdm_demux4x1: directed vector table, async-reset sequence, and randomized run vs a frame-level model.
module tb_tdm_demux4x1;

    localparam int W  = 4;
    localparam int ML = 2;
    localparam int VW = 4 * W + 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   in;
    logic           in_valid;
    logic           frame_sync;
    logic [W-1:0]   out0, out1, out2, out3;
    logic           frame_valid;
    logic [1:0]     slot;
    logic           locked;
    logic           sync_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdm_demux4x1 #(.WIDTH(W), .MISS_LIMIT(ML)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .in_valid    (in_valid),
        .frame_sync  (frame_sync),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    // Frame-level reference: a list of samples for the frame being assembled.
    bit           m_locked;
    int           m_slot;
    int           m_miss;
    logic [W-1:0] m_frame [$];
    logic [W-1:0] m_out [4];
    bit           m_fv;
    bit           m_err;

    function automatic void model_reset();
        m_locked = 0;
        m_slot   = 0;
        m_miss   = 0;
        m_frame.delete();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_fv  = 0;
        m_err = 0;
    endfunction

    function automatic void start_frame(logic [W-1:0] d);
        m_frame.delete();
        m_frame.push_back(d);
        m_slot = 1;
    endfunction

    function automatic void model_step(bit v, bit s, logic [W-1:0] d);
        m_fv  = 0;
        m_err = 0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_locked = 1;
                m_miss   = 0;
                start_frame(d);
            end
        end else if (s && m_slot != 0) begin
            m_err  = 1;
            m_miss = 0;
            start_frame(d);
        end else if (m_slot == 0) begin
            if (s) m_miss = 0;
            else   m_miss = m_miss + 1;
            if (!s && m_miss >= ML) begin
                m_err    = 1;
                m_locked = 0;
                m_slot   = 0;
                m_miss   = 0;
                m_frame.delete();
            end else begin
                start_frame(d);
            end
        end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                m_fv = 1;
                m_frame.delete();
                m_slot = 0;
            end else begin
                m_slot = m_slot + 1;
            end
        end
    endfunction

    function automatic logic [VW-1:0] obs();
        return {out0, out1, out2, out3, frame_valid, slot, locked, sync_err};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_out[0], m_out[1], m_out[2], m_out[3], m_fv, 2'(m_slot), m_locked, m_err};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (fields out0..out3,fv,slot,locked,err)", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [W-1:0] d, input string name);
        in_valid   = v;
        frame_sync = s;
        in         = d;
        model_step(v, s, d);
        @(posedge clk);
        #1;
        check(name, obs(), model_vec());
    endtask

    typedef struct {
        bit           v;
        bit           s;
        logic [W-1:0] d;
        logic [3:0]   o;   // {ch0,ch1,ch2,ch3} expected after the edge
        bit           fv;
        logic [1:0]   sl;
        bit           lk;
        bit           err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t r(bit v, bit s, int d, logic [3:0] o, bit fv, int sl, bit lk, bit err);
        vec_t x;
        x.v = v; x.s = s; x.d = W'(d); x.o = o;
        x.fv = fv; x.sl = 2'(sl); x.lk = lk; x.err = err;
        return x;
    endfunction

    function automatic logic [VW-1:0] tvec(vec_t x);
        return {W'(x.o[3]), W'(x.o[2]), W'(x.o[1]), W'(x.o[0]), x.fv, x.sl, x.lk, x.err};
    endfunction

    initial begin
        // one frame 1,0,0,0
        tbl.push_back(r(1,1,1, 4'b0000,0,1,1,0));
        tbl.push_back(r(1,0,0, 4'b0000,0,2,1,0));
        tbl.push_back(r(1,0,0, 4'b0000,0,3,1,0));
        tbl.push_back(r(1,0,0, 4'b1000,1,0,1,0));
        // walking one
        tbl.push_back(r(1,1,1, 4'b1000,0,1,1,0));
        tbl.push_back(r(1,0,0, 4'b1000,0,2,1,0));
        tbl.push_back(r(1,0,0, 4'b1000,0,3,1,0));
        tbl.push_back(r(1,0,0, 4'b1000,1,0,1,0));
        tbl.push_back(r(1,1,0, 4'b1000,0,1,1,0));
        tbl.push_back(r(1,0,1, 4'b1000,0,2,1,0));
        tbl.push_back(r(1,0,0, 4'b1000,0,3,1,0));
        tbl.push_back(r(1,0,0, 4'b0100,1,0,1,0));
        tbl.push_back(r(1,1,0, 4'b0100,0,1,1,0));
        tbl.push_back(r(1,0,0, 4'b0100,0,2,1,0));
        tbl.push_back(r(1,0,1, 4'b0100,0,3,1,0));
        tbl.push_back(r(1,0,0, 4'b0010,1,0,1,0));
        tbl.push_back(r(1,1,0, 4'b0010,0,1,1,0));
        tbl.push_back(r(1,0,0, 4'b0010,0,2,1,0));
        tbl.push_back(r(1,0,0, 4'b0010,0,3,1,0));
        tbl.push_back(r(1,0,1, 4'b0001,1,0,1,0));
        // early sync at slot 2, then the restarted frame completes as 0,1,1,0
        tbl.push_back(r(1,1,1, 4'b0001,0,1,1,0));
        tbl.push_back(r(1,0,1, 4'b0001,0,2,1,0));
        tbl.push_back(r(1,1,0, 4'b0001,0,1,1,1));
        tbl.push_back(r(1,0,1, 4'b0001,0,2,1,0));
        tbl.push_back(r(1,0,1, 4'b0001,0,3,1,0));
        tbl.push_back(r(1,0,0, 4'b0110,1,0,1,0));
        // first miss still decodes, second miss drops lock
        tbl.push_back(r(1,0,1, 4'b0110,0,1,1,0));
        tbl.push_back(r(1,0,0, 4'b0110,0,2,1,0));
        tbl.push_back(r(1,0,0, 4'b0110,0,3,1,0));
        tbl.push_back(r(1,0,1, 4'b1001,1,0,1,0));
        tbl.push_back(r(1,0,1, 4'b1001,0,0,0,1));
        tbl.push_back(r(0,0,0, 4'b1001,0,0,0,0));
        tbl.push_back(r(0,1,1, 4'b1001,0,0,0,0));
        // hunt filtering, then a synced frame with an idle cycle inside
        tbl.push_back(r(1,0,1, 4'b1001,0,0,0,0));
        tbl.push_back(r(1,0,0, 4'b1001,0,0,0,0));
        tbl.push_back(r(1,0,1, 4'b1001,0,0,0,0));
        tbl.push_back(r(1,0,1, 4'b1001,0,0,0,0));
        tbl.push_back(r(1,0,0, 4'b1001,0,0,0,0));
        tbl.push_back(r(1,1,0, 4'b1001,0,1,1,0));
        tbl.push_back(r(1,0,1, 4'b1001,0,2,1,0));
        tbl.push_back(r(0,0,1, 4'b1001,0,2,1,0));
        tbl.push_back(r(1,0,1, 4'b1001,0,3,1,0));
        tbl.push_back(r(1,0,0, 4'b0110,1,0,1,0));

        rst_n      = 1'b0;
        in         = '0;
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_state", obs(), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d, $sformatf("model_row%0d", i));
            check($sformatf("table_row%0d", i), obs(), tvec(tbl[i]));
        end

        // async reset between edges while at slot 2
        step(1, 1, W'(1), "pre_rst0");
        step(1, 0, W'(1), "pre_rst1");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_immediate", obs(), '0);
        @(posedge clk);
        #1;
        check("async_rst_held", obs(), '0);
        rst_n = 1'b1;
        step(1, 0, W'(1), "post_rst_nosync0");
        step(1, 0, W'(1), "post_rst_nosync1");
        step(1, 0, W'(0), "post_rst_nosync2");
        step(1, 1, W'(1), "post_rst_f0");
        step(1, 0, W'(1), "post_rst_f1");
        step(1, 0, W'(0), "post_rst_f2");
        step(1, 0, W'(1), "post_rst_f3");
        check("post_rst_frame", obs(),
              {W'(1), W'(1), W'(0), W'(1), 1'b1, 2'd0, 1'b1, 1'b0});

        // randomized traffic: mostly well-formed frames with occasional misses and early syncs
        for (int n = 0; n < 3000; n++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            if (!m_locked || m_slot == 0) s = ($urandom_range(0, 9) < 8);
            else                          s = ($urandom_range(0, 19) == 0);
            step(v, s, W'($urandom), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4x1.md
Name: tdm_demux4x1

Overview:
- Receive end of a 4-channel time-division link whose transmit end is a 4:1 mux driven by a 2-bit slot counter.
- Accepts one WIDTH-bit sample per in_valid, plus a frame_sync marker on slot 0.
- Rebuilds the four channel values and presents them together as one registered frame.
- Tracks frame lock and flags sync errors.

Parameters:
- WIDTH, 1, bits per channel sample.
- MISS_LIMIT, 2, consecutive frames whose slot 0 arrives without frame_sync before lock is dropped; legal range 1..7.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  serial sample for the current slot
- in_valid  input  1  in holds a valid sample this cycle
- frame_sync  input  1  qualified by in_valid; marks the sample as slot 0
- out0  output  WIDTH  channel 0 value of last complete frame
- out1  output  WIDTH  channel 1 value of last complete frame
- out2  output  WIDTH  channel 2 value of last complete frame
- out3  output  WIDTH  channel 3 value of last complete frame
- frame_valid  output  1  one-cycle pulse when out0..out3 update
- slot  output  2  slot index expected for the next sample ({s1,s0})
- locked  output  1  high in LOCKED state
- sync_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Reset (rst_n low, asynchronous):
  - out0..out3 = 0, frame_valid = 0, slot = 0, locked = 0, sync_err = 0.
  - Shadow registers cleared, miss counter = 0, state = HUNT.
  - Reset mid-frame discards the partial frame.
- in_valid low: nothing changes; all pulses deassert.
- State HUNT:
  - Samples without frame_sync are dropped; slot stays 0.
  - in_valid and frame_sync: capture in to shadow[0], slot becomes 1, go to LOCKED, miss counter cleared.
- State LOCKED, on each in_valid:
  - Capture in to shadow[slot], then slot = slot + 1 (wraps 3 to 0).
  - frame_sync with slot != 0: early sync.
    - Pulse sync_err next cycle.
    - Discard the partial frame, no frame_valid.
    - Treat the sample as slot 0: capture to shadow[0], slot becomes 1, miss counter cleared.
  - Sample at slot 0 without frame_sync:
    - Accept the sample normally and increment the miss counter.
    - When the counter reaches MISS_LIMIT, pulse sync_err, go to HUNT, set slot to 0, and drop the sample.
  - Sample at slot 0 with frame_sync: miss counter cleared.
  - Sample at slot 3 completes the frame:
    - Captured at edge N: out0..out2 load from shadow[0..2] and out3 loads from in, all at edge N.
    - frame_valid is high for exactly the cycle following edge N; latency 1 cycle from the final sample.
- Outputs hold their values between frames; a new frame replaces all four at once, never partially.
- Back-to-back in_valid every cycle is supported: one frame per 4 cycles, frame_valid pulses every 4th cycle.
- frame_sync without in_valid is ignored.

Decomposition:
- Shared package holds:
  - state encoding ST_HUNT = 1'b0, ST_LOCKED = 1'b1
  - slot width constant SLOT_W = 2
  - channel count constant N_CH = 4
- One natural sub-module, tdm_slot_counter:
  - 2-bit wrap counter with synchronous load-to-1 (sync) and clear-to-0 (drop lock).
  - Same rst_n and clk.

Test Plan:
- Reset then one frame:
  - Stimulus: frame_sync with samples 1,0,0,0 in slots 0..3, in_valid every cycle.
  - Required: locked rises after first sample; out0..out3 = 1,0,0,0; frame_valid high one cycle after the slot-3 sample.
- Walking one over four frames:
  - Stimulus: sync each frame; frames 1000, 0100, 0010, 0001.
  - Required: each frame decoded exactly as sent; slot sequence 0,1,2,3 repeating.
- HUNT filtering:
  - Stimulus: 5 samples without sync after reset, then a synced frame of 0,1,1,0.
  - Required: locked stays 0 and no frame_valid during the first 5; outputs 0,1,1,0 after the synced frame.
- Early sync:
  - Stimulus: frame_sync on slot 2.
  - Required: sync_err pulses once; no frame_valid for the broken frame; next full frame decodes correctly; outputs hold their previous frame until then.
- Lost sync, MISS_LIMIT = 2:
  - Stimulus: two consecutive frames with no sync at slot 0.
  - Required: first missed frame still decodes with frame_valid; on the second miss sync_err pulses, locked falls, slot = 0.
- Async reset mid-frame:
  - Stimulus: assert rst_n low between clock edges at slot 2.
  - Required: all outputs 0 immediately; no frame_valid after release until a new synced frame completes.
